// File: rtl/uart_rx_param_if.sv
// Receive-side bundle of the parametrised UART: the serial line in, and the
// one-word valid/ready holding register with its status flags out.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 brk;

  modport master (
    input  rx, rx_ready,
    output rx_data, rx_valid, frame_err, parity_err, overrun, brk
  );

  modport slave (
    output rx, rx_ready,
    input  rx_data, rx_valid, frame_err, parity_err, overrun, brk
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: fractional baud tick, 2-of-3 mid-bit voting,
// parity/framing/break/overrun detection, one-word valid/ready output register.
module uart_rx_param #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_param_if.master bus
);
  localparam longint INC   = longint'(BAUD) * longint'(OVERSAMPLE);
  localparam int     ACC_W = $clog2(longint'(CLK_HZ) + INC) + 1;
  localparam int     CNT_W = $clog2(OVERSAMPLE);
  localparam int     IDX_W = $clog2(DATA_BITS);

  localparam logic [ACC_W-1:0] INC_W    = ACC_W'(INC);
  localparam logic [ACC_W-1:0] CLK_W    = ACC_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] M_LO     = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] M_MID    = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] M_HI     = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKW} state_e;

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_sum;
  logic                 tick;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 stop_lo_q, stop_lo_d;
  logic                 stop_hi_q, stop_hi_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 maj, decide, bit_end, par_xor;
  logic                 done, done_ferr, done_perr, done_brk;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, perr_q, ovr_q, brk_q;

  // Phase accumulator never exceeds CLK_HZ+INC, so one subtraction per tick keeps it bounded.
  assign acc_sum = acc_q + INC_W;
  assign tick    = (acc_sum >= CLK_W);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      acc_q     <= tick ? (acc_sum - CLK_W) : acc_sum;
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign maj     = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
  assign decide  = tick && (cnt_q == M_HI);
  assign bit_end = tick && (cnt_q == CNT_LAST);
  assign par_xor = (^shift_q) ^ par_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_idx_d = stop_idx_q;
    stop_lo_d  = stop_lo_q;
    stop_hi_d  = stop_hi_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    done       = 1'b0;
    done_ferr  = 1'b0;
    done_perr  = 1'b0;
    done_brk   = 1'b0;

    if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == M_LO)  s0_d = rx_sync_q;
      if (cnt_q == M_MID) s1_d = rx_sync_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        idx_d      = '0;
        par_d      = 1'b0;
        stop_idx_d = 1'b0;
        stop_lo_d  = 1'b0;
        stop_hi_d  = 1'b0;
        if (rx_prev_q && !rx_sync_q) state_d = S_START;
      end
      S_START: begin
        if (decide && maj) state_d = S_IDLE;
        else if (bit_end)  state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (decide)  par_d   = maj;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          stop_lo_d = stop_lo_q | ~maj;
          stop_hi_d = stop_hi_q | maj;
          if (stop_idx_q == STOP_LAST) begin
            // The frame completes at the last stop-bit vote, not at the end of that bit.
            done      = 1'b1;
            done_ferr = stop_lo_q | ~maj;
            done_perr = (PARITY == 1) ? ~par_xor : ((PARITY == 2) ? par_xor : 1'b0);
            done_brk  = (shift_q == '0) & ~par_q & ~(stop_hi_q | maj);
            state_d   = done_brk ? S_BRKW : S_IDLE;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      S_BRKW: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_idx_q <= 1'b0;
      stop_lo_q  <= 1'b0;
      stop_hi_q  <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_idx_q <= stop_idx_d;
      stop_lo_q  <= stop_lo_d;
      stop_hi_q  <= stop_hi_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
    end
  end

  // Holding register: a completed frame that finds the register full and not being drained is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else if (done) begin
      if (!valid_q || bus.rx_ready) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        ferr_q  <= done_ferr;
        perr_q  <= done_perr;
        brk_q   <= done_brk;
        ovr_q   <= 1'b0;
      end else begin
        ovr_q   <= 1'b1;
      end
    end else if (valid_q && bus.rx_ready) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.parity_err = perr_q;
  assign bus.overrun    = ovr_q;
  assign bus.brk        = brk_q;
endmodule
